me_req_ctrl: RTL and testbench

ME_REQ_CTRL -- requirements
Module: me_req_ctrl

---
 rtl/me_pkg.sv | 16 +
 rtl/me_min_tracker.sv | 24 ++
 rtl/me_req_ctrl.sv | 93 +++++++++
 tb/tb_me_req_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// me_pkg: shared ME controller state encoding and width helpers
package me_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RELEASE, DONE} me_state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int tmr_w(input int t);
    return t > 1 ? $clog2(t) : 1;
  endfunction
  function automatic int sad_w(input int blk_px, input int px_bits);
    return px_bits + $clog2(blk_px);
  endfunction
  function automatic int cnt_w(input int positions);
    return positions > 1 ? $clog2(positions) : 1;
  endfunction
endpackage

// File: rtl/me_min_tracker.sv
// me_min_tracker: running minimum SAD and the block index that produced it
module me_min_tracker #(
  parameter int SAD_WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 valid,
  input  logic [SAD_WIDTH-1:0] sad,
  input  logic [IDX_W-1:0]     idx,
  output logic [SAD_WIDTH-1:0] best_sad,
  output logic [IDX_W-1:0]     best_idx
);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      best_sad <= '1;
      best_idx <= '0;
    end else if (valid && sad < best_sad) begin
      best_sad <= sad;
      best_idx <= idx;
    end
  end
endmodule

// File: rtl/me_req_ctrl.sv
// me_req_ctrl: sequences NUM_BLOCKS motion-estimation requests and collects results
module me_req_ctrl
  import me_pkg::*;
#(
  parameter int NUM_BLOCKS = 16,
  parameter int SAD_WIDTH = 16,
  parameter int CNT_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 1048576,
  localparam int IDX_W = idx_w(NUM_BLOCKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 me_req,
  input  logic                 me_ack,
  input  logic [SAD_WIDTH-1:0] me_min_sad,
  input  logic [CNT_WIDTH-1:0] me_min_mvec,
  output logic [IDX_W-1:0]     blk_idx,
  output logic                 res_we,
  output logic [IDX_W-1:0]     res_addr,
  output logic [SAD_WIDTH-1:0] res_sad,
  output logic [CNT_WIDTH-1:0] res_mvec,
  output logic [SAD_WIDTH-1:0] best_sad,
  output logic [IDX_W-1:0]     best_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);
  localparam int TMR_W = tmr_w(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BLOCKS - 1);
  me_state_t state, state_n;
  logic [TMR_W-1:0] timer;
  logic accept, capture, expire, last;
  assign accept = state == IDLE && start;
  assign capture = state == REQ && me_ack;
  assign expire = state == REQ && !me_ack && timer == TMR_MAX;
  assign last = blk_idx == LAST;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? REQ : IDLE;
      REQ:     state_n = me_ack ? RELEASE : expire ? IDLE : REQ;
      RELEASE: state_n = me_ack ? RELEASE : last ? DONE : REQ;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    me_req = state == REQ;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_idx <= '0;
      timer <= '0;
      res_we <= 1'b0;
      res_addr <= '0;
      res_sad <= '0;
      res_mvec <= '0;
      timeout_err <= 1'b0;
    end else begin
      res_we <= capture;
      if (capture) begin
        res_addr <= blk_idx;
        res_sad <= me_min_sad;
        res_mvec <= me_min_mvec;
      end
      if (accept) begin
        blk_idx <= '0;
        timer <= '0;
        timeout_err <= 1'b0;
      end else if (state == REQ) begin
        timer <= timer + 1'b1;
        if (expire) timeout_err <= 1'b1;
      end else if (state == RELEASE && !me_ack && !last) begin
        blk_idx <= blk_idx + 1'b1;
        timer <= '0;
      end
    end
  end
  me_min_tracker #(.SAD_WIDTH(SAD_WIDTH), .IDX_W(IDX_W)) u_min (
    .clk(clk),
    .rst(rst),
    .clear(accept),
    .valid(capture),
    .sad(me_min_sad),
    .idx(blk_idx),
    .best_sad(best_sad),
    .best_idx(best_idx)
  );
endmodule

// File: tb/tb_me_req_ctrl.sv
// tb_me_req_ctrl: directed checks of me_req_ctrl runs, ack hold, timeout, reset and single-block runs
module tb_me_req_ctrl;
  logic clk = 0, rst = 1, start = 0, me_ack = 0, start1 = 0, ack1 = 0;
  logic [15:0] me_min_sad = '0;
  logic [11:0] me_min_mvec = '0;
  logic me_req, res_we, busy, done, timeout_err;
  logic [1:0] blk_idx, res_addr, best_idx;
  logic [15:0] res_sad, best_sad;
  logic [11:0] res_mvec;
  logic me_req1, res_we1, busy1, done1, tmo1;
  logic [0:0] blk_idx1, res_addr1, best_idx1;
  logic [15:0] res_sad1, best_sad1;
  logic [11:0] res_mvec1;
  int checks = 0, fails = 0;
  int we_cnt = 0, done_cnt = 0, rise_cnt = 0, done1_cnt = 0, rise1_cnt = 0;
  logic req_q = 0, req1_q = 0;
  me_req_ctrl #(.NUM_BLOCKS(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .me_req(me_req), .me_ack(me_ack),
    .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec), .blk_idx(blk_idx),
    .res_we(res_we), .res_addr(res_addr), .res_sad(res_sad), .res_mvec(res_mvec),
    .best_sad(best_sad), .best_idx(best_idx), .busy(busy), .done(done),
    .timeout_err(timeout_err)
  );
  me_req_ctrl #(.NUM_BLOCKS(1), .TIMEOUT_CYCLES(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .me_req(me_req1), .me_ack(ack1),
    .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec), .blk_idx(blk_idx1),
    .res_we(res_we1), .res_addr(res_addr1), .res_sad(res_sad1), .res_mvec(res_mvec1),
    .best_sad(best_sad1), .best_idx(best_idx1), .busy(busy1), .done(done1),
    .timeout_err(tmo1)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    req_q <= me_req;
    req1_q <= me_req1;
    if (res_we) we_cnt <= we_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (me_req && !req_q) rise_cnt <= rise_cnt + 1;
    if (done1) done1_cnt <= done1_cnt + 1;
    if (me_req1 && !req1_q) rise1_cnt <= rise1_cnt + 1;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_req(input int idx);
    int n = 0;
    while (!me_req && n < 50) begin tick(); n++; end
    checks++; if (me_req !== 1'b1) begin fails++; $display("FAIL wait_req blk %0d: me_req=%b required 1 within 50 cycles", idx, me_req); end
    checks++; if (blk_idx !== 2'(idx)) begin fails++; $display("FAIL blk_idx: got %0d required %0d", blk_idx, idx); end
  endtask
  task automatic serve(input int idx, input logic [15:0] sad, input logic [11:0] mv, input int hold, input bit poke);
    wait_req(idx);
    for (int k = 0; k < 5; k++) begin
      start = poke && k == 1;
      tick();
    end
    start = 0;
    me_ack = 1; me_min_sad = sad; me_min_mvec = mv;
    tick();
    checks++; if (res_we !== 1'b1) begin fails++; $display("FAIL res_we blk %0d: got %b required 1", idx, res_we); end
    checks++; if (res_addr !== 2'(idx)) begin fails++; $display("FAIL res_addr: got %0d required %0d", res_addr, idx); end
    checks++; if (res_sad !== sad) begin fails++; $display("FAIL res_sad blk %0d: got %0d required %0d", idx, res_sad, sad); end
    checks++; if (res_mvec !== mv) begin fails++; $display("FAIL res_mvec blk %0d: got %0d required %0d", idx, res_mvec, mv); end
    checks++; if (me_req !== 1'b0) begin fails++; $display("FAIL me_req after capture blk %0d: got %b required 0", idx, me_req); end
    for (int h = 0; h < hold; h++) begin
      tick();
      checks++; if (res_we !== 1'b0 || me_req !== 1'b0) begin fails++; $display("FAIL ack_hold cycle %0d: res_we=%b me_req=%b required 0,0", h, res_we, me_req); end
    end
    me_ack = 0; me_min_sad = 16'hdead; me_min_mvec = 12'hbad;
  endtask
  task automatic test_reset;
    rst = 1; start = 1; me_ack = 1;
    tick(); tick();
    checks++; if (me_req !== 1'b0 || res_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset ctrl: me_req=%b res_we=%b busy=%b done=%b required 0000", me_req, res_we, busy, done); end
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset timeout_err: got %b required 0", timeout_err); end
    checks++; if (blk_idx !== 2'd0 || res_addr !== 2'd0 || best_idx !== 2'd0) begin fails++; $display("FAIL reset idx: blk=%0d addr=%0d best=%0d required 0", blk_idx, res_addr, best_idx); end
    checks++; if (res_sad !== 16'd0 || res_mvec !== 12'd0) begin fails++; $display("FAIL reset res: sad=%0d mvec=%0d required 0", res_sad, res_mvec); end
    checks++; if (best_sad !== 16'hffff) begin fails++; $display("FAIL reset best_sad: got %h required ffff", best_sad); end
    checks++; if (me_req1 !== 1'b0 || busy1 !== 1'b0 || best_sad1 !== 16'hffff) begin fails++; $display("FAIL reset dut1: me_req=%b busy=%b best_sad=%h required 0,0,ffff", me_req1, busy1, best_sad1); end
    rst = 0; start = 0; me_ack = 0;
    tick();
  endtask
  task automatic test_run;
    int w0 = we_cnt, d0 = done_cnt, r0 = rise_cnt;
    start = 1; tick(); start = 0;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL run busy: got %b required 1", busy); end
    serve(0, 16'd40, 12'd5, 0, 0);
    serve(1, 16'd12, 12'd17, 0, 0);
    serve(2, 16'd12, 12'd33, 0, 0);
    serve(3, 16'd30, 12'd64, 0, 0);
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL run done: done=%b busy=%b required 1,1", done, busy); end
    checks++; if (best_sad !== 16'd12 || best_idx !== 2'd1) begin fails++; $display("FAIL run best: sad=%0d idx=%0d required 12,1", best_sad, best_idx); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL run end: done=%b busy=%b required 0,0", done, busy); end
    checks++; if (we_cnt - w0 !== 4 || done_cnt - d0 !== 1 || rise_cnt - r0 !== 4) begin fails++; $display("FAIL run counts: we=%0d done=%0d req=%0d required 4,1,4", we_cnt - w0, done_cnt - d0, rise_cnt - r0); end
  endtask
  task automatic test_ack_hold_reset;
    int w0 = we_cnt;
    start = 1; tick(); start = 0;
    serve(0, 16'd50, 12'd1, 3, 0);
    tick();
    checks++; if (me_req !== 1'b1 || blk_idx !== 2'd1) begin fails++; $display("FAIL after ack fall: me_req=%b blk=%0d required 1,1", me_req, blk_idx); end
    serve(1, 16'd20, 12'd2, 0, 0);
    wait_req(2);
    repeat (5) tick();
    me_ack = 1; me_min_sad = 16'd3;
    tick();
    rst = 1;
    tick();
    checks++; if (me_req !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid reset ctrl: me_req=%b busy=%b required 0,0", me_req, busy); end
    checks++; if (best_sad !== 16'hffff || blk_idx !== 2'd0 || res_we !== 1'b0) begin fails++; $display("FAIL mid reset state: best_sad=%h blk=%0d res_we=%b required ffff,0,0", best_sad, blk_idx, res_we); end
    checks++; if (we_cnt - w0 !== 3) begin fails++; $display("FAIL ack hold writes: got %0d required 3", we_cnt - w0); end
    rst = 0; me_ack = 0;
    tick();
  endtask
  task automatic test_timeout;
    int w0 = we_cnt, d0 = done_cnt, n = 0;
    start = 1; tick(); start = 0;
    checks++; if (me_req !== 1'b1 || blk_idx !== 2'd0) begin fails++; $display("FAIL restart: me_req=%b blk=%0d required 1,0", me_req, blk_idx); end
    while (me_req && n < 40) begin n++; tick(); end
    checks++; if (n !== 16) begin fails++; $display("FAIL timeout req cycles: got %0d required 16", n); end
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL timeout flags: err=%b busy=%b required 1,0", timeout_err, busy); end
    repeat (3) tick();
    checks++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout sticky: got %b required 1", timeout_err); end
    checks++; if (we_cnt - w0 !== 0 || done_cnt - d0 !== 0) begin fails++; $display("FAIL timeout counts: we=%0d done=%0d required 0,0", we_cnt - w0, done_cnt - d0); end
  endtask
  task automatic test_busy_start;
    int w0, d0, r0;
    me_ack = 1; me_min_sad = 16'd1;
    repeat (3) tick();
    checks++; if (me_req !== 1'b0 || busy !== 1'b0 || res_we !== 1'b0 || timeout_err !== 1'b1) begin fails++; $display("FAIL stray ack: me_req=%b busy=%b res_we=%b err=%b required 0,0,0,1", me_req, busy, res_we, timeout_err); end
    me_ack = 0;
    tick();
    w0 = we_cnt; d0 = done_cnt; r0 = rise_cnt;
    start = 1; tick(); start = 0;
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL start clears err: err=%b busy=%b required 0,1", timeout_err, busy); end
    serve(0, 16'd100, 12'd9, 0, 1);
    serve(1, 16'd90, 12'd8, 0, 1);
    serve(2, 16'd200, 12'd7, 0, 1);
    serve(3, 16'd90, 12'd6, 0, 1);
    tick();
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL busy run done: got %b required 1", done); end
    repeat (5) tick();
    checks++; if (me_req !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL busy start idle: me_req=%b busy=%b required 0,0", me_req, busy); end
    checks++; if (rise_cnt - r0 !== 4 || we_cnt - w0 !== 4 || done_cnt - d0 !== 1) begin fails++; $display("FAIL busy start counts: req=%0d we=%0d done=%0d required 4,4,1", rise_cnt - r0, we_cnt - w0, done_cnt - d0); end
    checks++; if (best_sad !== 16'd90 || best_idx !== 2'd1) begin fails++; $display("FAIL busy best: sad=%0d idx=%0d required 90,1", best_sad, best_idx); end
  endtask
  task automatic test_single;
    int d0 = done1_cnt, r0 = rise1_cnt;
    start1 = 1; tick(); start1 = 0;
    checks++; if (me_req1 !== 1'b1 || busy1 !== 1'b1) begin fails++; $display("FAIL single req: me_req=%b busy=%b required 1,1", me_req1, busy1); end
    repeat (2) tick();
    ack1 = 1; me_min_sad = 16'd7; me_min_mvec = 12'd3;
    tick();
    checks++; if (res_we1 !== 1'b1 || me_req1 !== 1'b0 || res_sad1 !== 16'd7) begin fails++; $display("FAIL single capture: res_we=%b me_req=%b sad=%0d required 1,0,7", res_we1, me_req1, res_sad1); end
    ack1 = 0;
    tick();
    checks++; if (done1 !== 1'b1) begin fails++; $display("FAIL single done: got %b required 1", done1); end
    tick();
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin fails++; $display("FAIL single end: done=%b busy=%b required 0,0", done1, busy1); end
    repeat (3) tick();
    checks++; if (rise1_cnt - r0 !== 1 || done1_cnt - d0 !== 1 || best_sad1 !== 16'd7) begin fails++; $display("FAIL single counts: req=%0d done=%0d best=%0d required 1,1,7", rise1_cnt - r0, done1_cnt - d0, best_sad1); end
  endtask
  initial begin
    test_reset();
    test_run();
    test_ack_hold_reset();
    test_timeout();
    test_busy_start();
    test_single();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
